// File: rtl/v_mem_port_arbiter_if.sv
// Bundle of every signal crossing the shared data-memory port arbiter.
// The arbiter connects through the slave modport. The scalar core, the
// vector core load/store units and the data memory connect through the
// master modport, seen from outside the arbiter.
interface v_mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  // Scalar core load/store path
  logic                  s_load_req_i;
  logic                  s_store_req_i;
  logic [ADDR_WIDTH-1:0] s_addr_i;
  logic [DATA_WIDTH-1:0] s_wdata_i;
  logic                  s_gnt_o;
  logic                  s_stall_o;
  logic [DATA_WIDTH-1:0] s_rdata_o;
  logic                  s_rvalid_o;

  // Vector core load unit
  logic                  vl_req_i;
  logic [ADDR_WIDTH-1:0] vl_addr_i;
  logic                  vl_gnt_o;
  logic [DATA_WIDTH-1:0] vl_rdata_o;
  logic                  vl_rvalid_o;

  // Vector core store unit
  logic                  vs_req_i;
  logic [ADDR_WIDTH-1:0] vs_addr_i;
  logic [DATA_WIDTH-1:0] vs_wdata_i;
  logic                  vs_gnt_o;

  // Vector core drain flags
  logic                  all_v_stores_executed_i;
  logic                  all_v_loads_executed_i;

  // Data memory port
  logic                  mem_re_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  // Arbiter side
  modport slave (
    input  s_load_req_i, s_store_req_i, s_addr_i, s_wdata_i,
    output s_gnt_o, s_stall_o, s_rdata_o, s_rvalid_o,
    input  vl_req_i, vl_addr_i,
    output vl_gnt_o, vl_rdata_o, vl_rvalid_o,
    input  vs_req_i, vs_addr_i, vs_wdata_i,
    output vs_gnt_o,
    input  all_v_stores_executed_i, all_v_loads_executed_i,
    output mem_re_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  // Requesters and memory side
  modport master (
    output s_load_req_i, s_store_req_i, s_addr_i, s_wdata_i,
    input  s_gnt_o, s_stall_o, s_rdata_o, s_rvalid_o,
    output vl_req_i, vl_addr_i,
    input  vl_gnt_o, vl_rdata_o, vl_rvalid_o,
    output vs_req_i, vs_addr_i, vs_wdata_i,
    input  vs_gnt_o,
    output all_v_stores_executed_i, all_v_loads_executed_i,
    input  mem_re_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/v_mem_port_arbiter.sv
// Arbiter for the single data-memory port shared by the scalar load/store
// path, the vector load unit and the vector store unit.
// - Scalar accesses wait for the vector core to drain (loads wait for vector
//   stores, stores wait for both vector loads and stores).
// - Scalar normally wins; after MAX_WAIT consecutive denied vector cycles the
//   vector side gets top priority for one grant.
// - Vector load and store are round-robined against each other.
// - Read data returns one cycle after the grant, steered by a registered
//   owner tag; stores produce no response.
module v_mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input logic                 clk,
  input logic                 reset,
  v_mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]      WAIT_MAX  = CNT_W'(MAX_WAIT);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = '0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;

  // Round-robin memory of the last vector unit served
  localparam logic RR_VL = 1'b0;
  localparam logic RR_VS = 1'b1;

  // Who owns the read data returning this cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_S    = 2'd1,
    OWN_VL   = 2'd2
  } owner_e;

  // Winner of the port in the current cycle
  typedef enum logic [2:0] {
    WIN_NONE = 3'd0,
    WIN_SL   = 3'd1,
    WIN_SS   = 3'd2,
    WIN_VL   = 3'd3,
    WIN_VS   = 3'd4
  } win_e;

  owner_e           rd_owner_q, rd_owner_d;
  logic             rr_last_q,  rr_last_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  win_e win;
  win_e vec_win;
  win_e sca_win;

  logic s_load_ok;
  logic s_store_ok;
  logic v_any;
  logic v_gnt;
  logic starve;

  // A load only has to wait for vector stores; a store must also let vector
  // loads finish so it cannot overwrite data they have not yet read. A
  // simultaneous load and store request is illegal; the load is taken.
  assign s_load_ok  = bus.s_load_req_i & bus.all_v_stores_executed_i;
  assign s_store_ok = ~bus.s_load_req_i & bus.s_store_req_i
                    & bus.all_v_stores_executed_i & bus.all_v_loads_executed_i;

  assign v_any  = bus.vl_req_i | bus.vs_req_i;
  assign v_gnt  = (win == WIN_VL) || (win == WIN_VS);
  assign starve = (wait_cnt_q == WAIT_MAX);

  // State register: read owner tag, round-robin pointer, starvation counter
  // NOTE: registered state is assigned with non-blocking (<=) so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_owner_q <= OWN_NONE;
      rr_last_q  <= RR_VS;
      wait_cnt_q <= '0;
    end else begin
      rd_owner_q <= rd_owner_d;
      rr_last_q  <= rr_last_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Arbitration: pick the single winner from requests and registered state
  // NOTE: every variable gets a default at the top of a combinational block,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    vec_win = WIN_NONE;
    sca_win = WIN_NONE;
    win     = WIN_NONE;

    if (bus.vl_req_i && bus.vs_req_i) begin
      vec_win = (rr_last_q == RR_VS) ? WIN_VL : WIN_VS;
    end else if (bus.vl_req_i) begin
      vec_win = WIN_VL;
    end else if (bus.vs_req_i) begin
      vec_win = WIN_VS;
    end

    if (s_load_ok) begin
      sca_win = WIN_SL;
    end else if (s_store_ok) begin
      sca_win = WIN_SS;
    end

    if (reset) begin
      win = WIN_NONE;
    end else if (starve && (vec_win != WIN_NONE)) begin
      win = vec_win;
    end else if (sca_win != WIN_NONE) begin
      win = sca_win;
    end else begin
      win = vec_win;
    end
  end

  // Next state: tag the read owner, advance round-robin, update wait counter
  always_comb begin
    rd_owner_d = OWN_NONE;
    rr_last_d  = rr_last_q;
    wait_cnt_d = wait_cnt_q;

    case (win)
      WIN_SL:  rd_owner_d = OWN_S;
      WIN_VL:  rd_owner_d = OWN_VL;
      default: rd_owner_d = OWN_NONE;
    endcase

    if (win == WIN_VL) begin
      rr_last_d = RR_VL;
    end else if (win == WIN_VS) begin
      rr_last_d = RR_VS;
    end

    // Counts consecutive cycles a vector request is pending and denied;
    // saturates at MAX_WAIT, which is the starvation threshold.
    if (v_gnt || !v_any) begin
      wait_cnt_d = '0;
    end else if (!starve) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  // Outputs: grants, memory command, stall and read-data steering
  always_comb begin
    bus.s_gnt_o     = 1'b0;
    bus.vl_gnt_o    = 1'b0;
    bus.vs_gnt_o    = 1'b0;
    bus.mem_re_o    = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = ADDR_ZERO;
    bus.mem_wdata_o = DATA_ZERO;

    case (win)
      WIN_SL: begin
        bus.s_gnt_o    = 1'b1;
        bus.mem_re_o   = 1'b1;
        bus.mem_addr_o = bus.s_addr_i;
      end
      WIN_SS: begin
        bus.s_gnt_o     = 1'b1;
        bus.mem_we_o    = 1'b1;
        bus.mem_addr_o  = bus.s_addr_i;
        bus.mem_wdata_o = bus.s_wdata_i;
      end
      WIN_VL: begin
        bus.vl_gnt_o   = 1'b1;
        bus.mem_re_o   = 1'b1;
        bus.mem_addr_o = bus.vl_addr_i;
      end
      WIN_VS: begin
        bus.vs_gnt_o    = 1'b1;
        bus.mem_we_o    = 1'b1;
        bus.mem_addr_o  = bus.vs_addr_i;
        bus.mem_wdata_o = bus.vs_wdata_i;
      end
      default: ;
    endcase

    bus.s_stall_o = (bus.s_load_req_i | bus.s_store_req_i)
                  & ~((win == WIN_SL) || (win == WIN_SS));

    // Read data is steered to whichever requester owned last cycle's read;
    // the other requester sees zero.
    bus.s_rvalid_o  = (rd_owner_q == OWN_S);
    bus.vl_rvalid_o = (rd_owner_q == OWN_VL);
    bus.s_rdata_o   = (rd_owner_q == OWN_S)  ? bus.mem_rdata_i : DATA_ZERO;
    bus.vl_rdata_o  = (rd_owner_q == OWN_VL) ? bus.mem_rdata_i : DATA_ZERO;
  end

endmodule
